// File: rtl/sram_controller.sv
// Splits 32-bit CPU accesses into two 16-bit SRAM half-word phases (low half first),
// each held for WAIT_CYCLES+1 cycles. ready stalls the requester while an access is in flight.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [16:0]   word;
  logic [31:0]   data_q;
  logic          is_write;
  logic [31:0]   offset;
  logic          phase_end;
  logic          request;
  logic          drive;
  logic [15:0]   dq_out;
  logic          unused_bits;

  // Addresses below BASE_ADDR simply wrap around; only the word index reaches the SRAM.
  assign offset      = address - BASE_ADDR;
  assign unused_bits = ^{offset[31:19], offset[1:0]};
  assign phase_end   = (cnt == LAST);
  assign request     = wr_en | rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      data_q    <= '0;
      is_write  <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            word     <= offset[18:2];
            data_q   <= write_data;
            is_write <= wr_en;
            cnt      <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= HIGH;
            if (!is_write) read_data[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= DONE;
            if (!is_write) read_data[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from state so a reset releases DQ in the same cycle.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    drive     = 1'b0;
    dq_out    = data_q[15:0];
    case (state)
      LOW: begin
        SRAM_ADDR = {word, 1'b0};
        SRAM_WE_N = ~is_write;
        drive     = is_write;
        dq_out    = data_q[15:0];
      end
      HIGH: begin
        SRAM_ADDR = {word, 1'b1};
        SRAM_WE_N = ~is_write;
        drive     = is_write;
        dq_out    = data_q[31:16];
      end
      default: ;
    endcase
  end

  assign SRAM_DQ = drive ? dq_out : 16'hzzzz;
  assign ready   = ((state == IDLE) && !request) || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: a WAIT_CYCLES=5 controller plus a WAIT_CYCLES=0 instance for back-to-back
// timing, each attached to a small behavioural asynchronous SRAM.
module tb_sram_controller;

  logic        clk;
  logic        rst;

  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, SRAM_WE_N;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic [15:0] mem [0:63];

  logic        wr0, rd0;
  logic [31:0] addr0, wd0, rdata0;
  logic        ready0, we0_n;
  logic [17:0] sa0;
  wire  [15:0] dq0;
  logic [15:0] mem0 [0:3];

  int errors = 0;
  int checks = 0;

  int          rc, we_low;
  logic [17:0] a_first, a_last;
  logic [31:0] rdv;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
    .write_data(wd0), .read_data(rdata0), .ready(ready0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The SRAMs drive the bus whenever not being written and latch writes mid-cycle.
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;
  assign dq0     = we0_n ? mem0[sa0[1:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ;
    if (!we0_n) mem0[sa0[1:0]] <= dq0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the WAIT_CYCLES=5 controller and follows it to completion.
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                               input logic [31:0] d, output int rcyc, output int wlow,
                               output logic [17:0] af, output logic [17:0] al,
                               output logic [31:0] rdat);
    wr_en      = we;
    rd_en      = re;
    address    = a;
    write_data = d;
    rcyc = -1;
    wlow = 0;
    af   = '0;
    al   = '0;
    rdat = '0;
    #1;
    checkOutput("ready_request_cycle", 32'(ready), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) af = SRAM_ADDR;
      if (ready) begin
        rcyc = k;
        rdat = read_data;
        break;
      end
      al = SRAM_ADDR;
      if (!SRAM_WE_N) wlow++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    wr0 = 1'b0; rd0 = 1'b0; addr0 = '0; wd0 = '0;
    repeat (3) step();
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_we_n", 32'(SRAM_WE_N), 32'd1);
    checkOutput("reset_addr", 32'(SRAM_ADDR), 32'd0);
    checkOutput("reset_read_data", read_data, 32'd0);
    rst = 1'b1;
    step();

    $display("[TB] write 0x12345678 @1024");
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h12345678, rc, we_low, a_first, a_last, rdv);
    checkOutput("t1_ready_cycle", 32'(rc), 32'd13);
    checkOutput("t1_we_low_cycles", 32'(we_low), 32'd12);
    checkOutput("t1_addr_first", 32'(a_first), 32'd0);
    checkOutput("t1_addr_last", 32'(a_last), 32'd1);
    checkOutput("t1_mem0", 32'(mem[0]), 32'h5678);
    checkOutput("t1_mem1", 32'(mem[1]), 32'h1234);
    checkOutput("t1_read_data_kept", read_data, 32'd0);

    $display("[TB] read @1024");
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, rc, we_low, a_first, a_last, rdv);
    checkOutput("t2_ready_cycle", 32'(rc), 32'd13);
    checkOutput("t2_read_data", rdv, 32'h12345678);
    checkOutput("t2_we_low_cycles", 32'(we_low), 32'd0);
    checkOutput("t2_mem_intact", 32'(mem[1]), 32'h1234);

    $display("[TB] write 0xDEADBEEF @1028");
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, rc, we_low, a_first, a_last, rdv);
    checkOutput("t3_addr_first", 32'(a_first), 32'd2);
    checkOutput("t3_addr_last", 32'(a_last), 32'd3);
    checkOutput("t3_mem2", 32'(mem[2]), 32'hBEEF);
    checkOutput("t3_mem3", 32'(mem[3]), 32'hDEAD);
    checkOutput("t3_idle_addr", 32'(SRAM_ADDR), 32'd0);

    $display("[TB] simultaneous rd/wr 0xA5A55A5A @1032");
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, rc, we_low, a_first, a_last, rdv);
    checkOutput("t4_ready_cycle", 32'(rc), 32'd13);
    checkOutput("t4_we_low_cycles", 32'(we_low), 32'd12);
    checkOutput("t4_mem4", 32'(mem[4]), 32'h5A5A);
    checkOutput("t4_mem5", 32'(mem[5]), 32'hA5A5);
    checkOutput("t4_read_data_kept", read_data, 32'h12345678);

    $display("[TB] write below base address wraps");
    applyStimulus(1'b1, 1'b0, 32'd1020, 32'h0BAD0C0D, rc, we_low, a_first, a_last, rdv);
    checkOutput("wrap_addr_first", 32'(a_first), 32'h3FFFE);
    checkOutput("wrap_addr_last", 32'(a_last), 32'h3FFFF);
    checkOutput("wrap_mem_lo", 32'(mem[62]), 32'h0C0D);
    checkOutput("wrap_mem_hi", 32'(mem[63]), 32'h0BAD);

    $display("[TB] reset during HIGH phase of a write");
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
    repeat (8) step();
    checkOutput("t5_high_addr", 32'(SRAM_ADDR), 32'd7);
    checkOutput("t5_high_we_n", 32'(SRAM_WE_N), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t5_we_n", 32'(SRAM_WE_N), 32'd1);
    checkOutput("t5_addr", 32'(SRAM_ADDR), 32'd0);
    checkOutput("t5_read_data", read_data, 32'd0);
    checkOutput("t5_no_ready", 32'(ready), 32'd0);
    repeat (2) step();
    checkOutput("t5_no_ready_held", 32'(ready), 32'd0);
    checkOutput("t5_mem6", 32'(mem[6]), 32'h2222);
    rst = 1'b1;
    wr_en = 1'b0;
    #1;
    checkOutput("t5_idle_ready", 32'(ready), 32'd1);
    step();

    $display("[TB] back-to-back write then read, WAIT_CYCLES=0");
    wr0 = 1'b1; addr0 = 32'd1028; wd0 = 32'hCAFEF00D;
    #1;
    checkOutput("t6_c0_ready", 32'(ready0), 32'd0);
    step();
    checkOutput("t6_c1_ready", 32'(ready0), 32'd0);
    checkOutput("t6_c1_we_n", 32'(we0_n), 32'd0);
    checkOutput("t6_c1_addr", 32'(sa0), 32'd2);
    step();
    checkOutput("t6_c2_ready", 32'(ready0), 32'd0);
    checkOutput("t6_c2_addr", 32'(sa0), 32'd3);
    step();
    checkOutput("t6_c3_ready", 32'(ready0), 32'd1);
    wr0 = 1'b0; rd0 = 1'b1;
    step();
    checkOutput("t6_c4_ready", 32'(ready0), 32'd0);
    step();
    checkOutput("t6_c5_addr", 32'(sa0), 32'd2);
    checkOutput("t6_c5_we_n", 32'(we0_n), 32'd1);
    step();
    checkOutput("t6_c6_addr", 32'(sa0), 32'd3);
    checkOutput("t6_c6_ready", 32'(ready0), 32'd0);
    step();
    checkOutput("t6_c7_ready", 32'(ready0), 32'd1);
    checkOutput("t6_c7_read_data", rdata0, 32'hCAFEF00D);
    rd0 = 1'b0;
    step();
    checkOutput("t6_idle_ready", 32'(ready0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
